reply_tracker: RTL and testbench
================================

# reply_tracker

Parametrised reply-frame tracker for the RS422 command/science link. It arms on a reply strobe while the link state matches a configured value, then counts received bytes against a frame length latched at arm time. It enforces an inter-byte gap limit and a post-frame quiet window, and reports completion or the specific failure to the command controller. It sits beside the RS422 receive path, taking `wen` from the receive-control block, and generalises the fixed 268-byte, 1 ms / 200 µs reply monitor.

## Interface
- `LEN_W`, 10 — width of frame-length and byte-count values
- `ARM_ST`, 3'b001 — `st` value that allows arming
- `GAP_CYC`, 12000 — maximum clock cycles between bytes in RECV (1 ms at 12 MHz)
- `QUIET_CYC`, 2400 — silence required after the last byte (200 µs at 12 MHz)
- `clk`  in  1  system clock; one clock domain only
- `rst_n`  in  1  asynchronous, active-low reset
- `st`  in  3  link state from the RS422 control FSM
- `newreply`  in  1  one-cycle reply-start strobe
- `wen`  in  1  one-cycle byte-received strobe
- `exp_len`  in  LEN_W  expected payload bytes; sampled only on arm
- `reply`  out  1  reply-busy indicator: registered "not IDLE" OR `newreply`
- `byte_cnt`  out  LEN_W  bytes counted in the current frame
- `done`  out  1  one-cycle pulse when the quiet window expires
- `ok`  out  1  valid with `done`; 1 = no overrun in this frame
- `err_gap`  out  1  one-cycle pulse on inter-byte timeout
- `err_abort`  out  1  one-cycle pulse when `newreply` interrupts an active frame

## Operation
- FSM states are IDLE, RECV and QUIET.
- **IDLE**
  - On `newreply && st==ARM_ST`: latch `exp_len`, clear `byte_cnt` and the overrun flag.
  - If the latched `exp_len` is nonzero, go to RECV; if it is 0, go straight to QUIET.
  - `wen` is ignored in IDLE.
- **RECV**
  - Each `wen` increments `byte_cnt` and restarts the gap timer.
  - The `wen` that makes `byte_cnt` equal the latched length moves the FSM to QUIET.
  - If the gap timer reaches GAP_CYC with no `wen`: pulse `err_gap` and go to IDLE.
- **QUIET**
  - The quiet timer starts from 0 on entry.
  - Each `wen` sets the overrun flag, increments `byte_cnt` (saturating at all-ones) and restarts the quiet timer.
  - When the timer reaches QUIET_CYC: pulse `done` with `ok = ~overrun`, then go to IDLE.
- **`newreply` in RECV or QUIET**
  - Pulse `err_abort`.
  - If `st==ARM_ST`, re-arm immediately: relatch `exp_len`, clear counters, and enter RECV (or QUIET if the length is 0).
  - Otherwise go to IDLE.
- **Simultaneous events, in priority order**
  - `newreply` beats `wen`, timer expiry and last-byte completion.
  - `wen` beats gap expiry and quiet expiry on the same cycle: the byte is counted and the timer restarts.
- **Arithmetic**
  - Timers are $clog2(max(GAP_CYC,QUIET_CYC))+1 bits.
  - Timers and the byte counter are unsigned and never wrap; the byte counter saturates.
- **Reset mid-operation:** all state returns to reset values immediately and no pulses are emitted.

## Timing
- Reset values: `reply`, `done`, `ok`, `err_gap`, `err_abort` = 0; `byte_cnt` = 0; FSM = IDLE.
- `reply` rises combinationally with `newreply`. Its registered term goes high one cycle after arming and falls one cycle after the FSM returns to IDLE.
- All pulses are registered and occur exactly 1 cycle wide, on the cycle after the deciding event.
- `byte_cnt` updates on the cycle after each `wen`.
- Gap timeout: `err_gap` is high exactly GAP_CYC+1 cycles after the last `wen` (or after entering RECV).
- Quiet expiry: `done` is high QUIET_CYC+1 cycles after the last counted byte, or after entry to QUIET.
- Outside `done`, `ok` holds 0.

## Structure
- Package `reply_pkg` holds:
  - FSM state encoding (one-hot localparams `RT_IDLE`, `RT_RECV`, `RT_QUIET`)
  - default cycle constants `RT_GAP_1MS=12000` and `RT_QUIET_200US=2400`
- Sub-module `reply_timer`: up-counter with synchronous clear and an `expire` output at a terminal count parameter. It is instantiated twice, once for the gap timer and once for the quiet timer.
- Byte counting and the FSM stay in the top module.

## Test plan
- **Clean frame:** `exp_len=268`, arm, 268 `wen` at 100-cycle spacing, then silence → single `done` with `ok=1`, `byte_cnt=268`, `reply` high throughout and low after `done`.
- **Gap timeout:** `exp_len=4`, arm, 2 bytes, then silence → `err_gap` exactly 12001 cycles after the 2nd `wen`, `byte_cnt=2`, no `done`.
- **Overrun:** `exp_len=3`, 3 bytes, 4th `wen` 500 cycles later → `done` 2401 cycles after the 4th byte with `ok=0`, `byte_cnt=4`.
- **Abort and re-arm:** mid-frame `newreply` with `st=001` and new `exp_len=2` → `err_abort` pulse, counters cleared, 2 bytes + quiet → `done`, `ok=1`. Repeat with `st=010` → FSM returns to IDLE, no `done`.
- **Boundary cases:**
  - `exp_len=0` → `done` after 2401 cycles.
  - `wen` on the exact gap-expiry cycle → counted, no `err_gap`.
  - `newreply` with `st≠001` in IDLE → nothing.
- **Reset mid-QUIET:** assert `rst_n` low for 1 cycle → all outputs 0 at once, no `done` afterwards.

Source files
------------

// File: rtl/reply_pkg.sv
// Shared encodings and default timing constants for the reply-frame tracker.
package reply_pkg;

  // One-hot FSM state encoding
  localparam logic [2:0] RT_IDLE  = 3'b001;
  localparam logic [2:0] RT_RECV  = 3'b010;
  localparam logic [2:0] RT_QUIET = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE  = RT_IDLE,
    S_RECV  = RT_RECV,
    S_QUIET = RT_QUIET
  } rt_state_e;

  // Default limits at a 12 MHz system clock
  localparam int RT_GAP_1MS     = 12000;
  localparam int RT_QUIET_200US = 2400;

  // Timer width: enough bits to reach the larger terminal count, plus one spare
  function automatic int rt_timer_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/reply_tracker_if.sv
// Control/status bundle between the RS422 receive control and the reply tracker.
interface reply_tracker_if #(
  parameter int LEN_W = 10
);
  logic [2:0]       st;
  logic             newreply;
  logic             wen;
  logic [LEN_W-1:0] exp_len;
  logic             reply;
  logic [LEN_W-1:0] byte_cnt;
  logic             done;
  logic             ok;
  logic             err_gap;
  logic             err_abort;

  modport master (
    output st, newreply, wen, exp_len,
    input  reply, byte_cnt, done, ok, err_gap, err_abort
  );

  modport slave (
    input  st, newreply, wen, exp_len,
    output reply, byte_cnt, done, ok, err_gap, err_abort
  );
endinterface

// File: rtl/reply_timer.sv
// Up-counter with synchronous clear; holds at and flags the terminal count.
module reply_timer #(
  parameter int W    = 15,
  parameter int TERM = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [W-1:0] r_cnt;

  assign o_expire = (r_cnt == W'(TERM));

  // Count up while enabled, stopping at the terminal count so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reply_tracker.sv
// Reply-frame tracker: arms on a reply strobe, counts bytes against a latched
// length, enforces the inter-byte gap and post-frame quiet window.
module reply_tracker
  import reply_pkg::*;
#(
  parameter int         LEN_W     = 10,
  parameter logic [2:0] ARM_ST    = 3'b001,
  parameter int         GAP_CYC   = RT_GAP_1MS,
  parameter int         QUIET_CYC = RT_QUIET_200US
) (
  input  logic           clk,
  input  logic           rst_n,
  reply_tracker_if.slave bus
);

  localparam int TMR_W = rt_timer_w(GAP_CYC, QUIET_CYC);

  rt_state_e        r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_byte_cnt, w_cnt_nxt, w_cnt_inc, w_cnt_sat;
  logic             r_ovr, w_ovr_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ok, w_ok_nxt;
  logic             r_err_gap, w_err_gap_nxt;
  logic             r_err_abort, w_err_abort_nxt;

  logic w_arm, w_in_idle, w_in_recv, w_in_quiet;
  logic w_gap_clr, w_gap_expire, w_quiet_clr, w_quiet_expire;

  assign w_arm      = bus.newreply && (bus.st == ARM_ST);
  assign w_in_idle  = (r_state == S_IDLE);
  assign w_in_recv  = (r_state == S_RECV);
  assign w_in_quiet = (r_state == S_QUIET);
  assign w_cnt_inc  = r_byte_cnt + 1'b1;
  assign w_cnt_sat  = (&r_byte_cnt) ? r_byte_cnt : w_cnt_inc;

  // Timers sit at zero outside their state, so entering the state starts from 0;
  // a byte or a reply strobe restarts them.
  assign w_gap_clr   = !w_in_recv  || bus.wen || bus.newreply;
  assign w_quiet_clr = !w_in_quiet || bus.wen || bus.newreply;

  reply_timer #(.W(TMR_W), .TERM(GAP_CYC)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_gap_clr),
    .i_en     (w_in_recv),
    .o_expire (w_gap_expire)
  );

  reply_timer #(.W(TMR_W), .TERM(QUIET_CYC)) u_quiet_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_quiet_clr),
    .i_en     (w_in_quiet),
    .o_expire (w_quiet_expire)
  );

  // Next-state and pulse decode; newreply outranks bytes, bytes outrank timers
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_cnt_nxt       = r_byte_cnt;
    w_ovr_nxt       = r_ovr;
    w_done_nxt      = 1'b0;
    w_ok_nxt        = 1'b0;
    w_err_gap_nxt   = 1'b0;
    w_err_abort_nxt = 1'b0;

    if (bus.newreply && !w_in_idle) begin
      w_err_abort_nxt = 1'b1;
    end

    if (w_arm) begin
      w_len_nxt   = bus.exp_len;
      w_cnt_nxt   = '0;
      w_ovr_nxt   = 1'b0;
      w_state_nxt = (bus.exp_len == '0) ? S_QUIET : S_RECV;
    end else if (bus.newreply) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // bytes outside a frame are ignored
        end
        S_RECV: begin
          if (bus.wen) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              w_state_nxt = S_QUIET;
            end
          end else if (w_gap_expire) begin
            w_err_gap_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end
        end
        S_QUIET: begin
          if (bus.wen) begin
            w_ovr_nxt = 1'b1;
            w_cnt_nxt = w_cnt_sat;
          end else if (w_quiet_expire) begin
            w_done_nxt  = 1'b1;
            w_ok_nxt    = ~r_ovr;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, frame bookkeeping and registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_byte_cnt  <= '0;
      r_ovr       <= 1'b0;
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_err_gap   <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_byte_cnt  <= w_cnt_nxt;
      r_ovr       <= w_ovr_nxt;
      r_done      <= w_done_nxt;
      r_ok        <= w_ok_nxt;
      r_err_gap   <= w_err_gap_nxt;
      r_err_abort <= w_err_abort_nxt;
    end
  end

  assign bus.reply     = !w_in_idle || bus.newreply;
  assign bus.byte_cnt  = r_byte_cnt;
  assign bus.done      = r_done;
  assign bus.ok        = r_ok;
  assign bus.err_gap   = r_err_gap;
  assign bus.err_abort = r_err_abort;

endmodule

// File: tb/tb_reply_tracker.sv
// Self-checking bench for reply_tracker: vector table, directed corner
// sequences, and a randomized run against a timestamp-based reference model.
module tb_reply_tracker;
  import reply_pkg::*;

  localparam int         LEN_W = 10;
  localparam int         G     = RT_GAP_1MS;
  localparam int         Q     = RT_QUIET_200US;
  localparam logic [2:0] ARM   = 3'b001;
  localparam logic [2:0] NOARM = 3'b010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reply_tracker_if #(.LEN_W(LEN_W)) bus ();

  reply_tracker #(
    .LEN_W(LEN_W), .ARM_ST(ARM), .GAP_CYC(G), .QUIET_CYC(Q)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event timestamps, not timers) ----------
  int     m_phase;   // 0 = no frame, 1 = collecting bytes, 2 = waiting for silence
  int     m_len, m_cnt;
  bit     m_ovr;
  longint cyc, mark; // mark = edge of last restart event
  bit     e_done, e_ok, e_gap, e_abort;

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_cnt = 0; m_ovr = 0;
    e_done = 0; e_ok = 0; e_gap = 0; e_abort = 0;
  endtask

  task automatic model_edge(input bit nr, input bit w, input logic [2:0] s, input int len);
    cyc++;
    e_done = 0; e_ok = 0; e_gap = 0; e_abort = 0;
    if (nr) begin
      if (m_phase != 0) e_abort = 1;
      if (s == ARM) begin
        m_len = len; m_cnt = 0; m_ovr = 0; mark = cyc;
        m_phase = (len == 0) ? 2 : 1;
      end else begin
        m_phase = 0;
      end
    end else if (m_phase == 1) begin
      if (w) begin
        m_cnt++; mark = cyc;
        if (m_cnt == m_len) m_phase = 2;
      end else if (cyc - mark == longint'(G + 1)) begin
        e_gap = 1; m_phase = 0;
      end
    end else if (m_phase == 2) begin
      if (w) begin
        m_ovr = 1; mark = cyc;
        if (m_cnt < (1 << LEN_W) - 1) m_cnt++;
      end else if (cyc - mark == longint'(Q + 1)) begin
        e_done = 1; e_ok = !m_ovr; m_phase = 0;
      end
    end
  endtask

  function automatic logic [31:0] dut_bundle();
    return 32'({bus.reply, bus.byte_cnt, bus.done, bus.ok, bus.err_gap, bus.err_abort});
  endfunction

  function automatic logic [31:0] model_bundle();
    logic       r;
    logic [9:0] c;
    r = (m_phase != 0) || bus.newreply;
    c = 10'(m_cnt);
    return 32'({r, c, e_done, e_ok, e_gap, e_abort});
  endfunction

  // One clock: drive inputs, advance model on the edge, compare just after it
  task automatic step(input bit nr, input bit w, input logic [2:0] s, input logic [LEN_W-1:0] len);
    bus.newreply = nr; bus.wen = w; bus.st = s; bus.exp_len = len;
    @(posedge clk);
    model_edge(nr, w, s, int'(len));
    #1;
    check("model", dut_bundle(), model_bundle());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ARM, '0);
  endtask

  // Idle until a status pulse appears; k = cycles waited, -1 if none in budget
  task automatic wait_pulse(input int budget, output int k, output logic d, output logic o, output logic g);
    k = -1; d = 0; o = 0; g = 0;
    for (int i = 1; i <= budget; i++) begin
      step(1'b0, 1'b0, ARM, '0);
      if (bus.done || bus.err_gap || bus.err_abort) begin
        k = i; d = bus.done; o = bus.ok; g = bus.err_gap;
        break;
      end
    end
  endtask

  typedef struct {
    logic             nr;
    logic             w;
    logic [2:0]       s;
    logic [LEN_W-1:0] len;
    logic             e_reply;
    logic [LEN_W-1:0] e_cnt;
    logic             e_abort;
  } vec_t;

  vec_t vecs[11];
  int   k;
  logic pd, po, pg;
  bit   all_high;

  initial begin
    bus.newreply = 0; bus.wen = 0; bus.st = ARM; bus.exp_len = '0;
    model_reset();
    cyc = 0; mark = 0;

    // Reset state
    #22;
    check("reset_outputs", dut_bundle(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table: short single-cycle behaviours ----
    vecs[0]  = '{1'b0, 1'b0, ARM,   10'd0, 1'b0, 10'd0, 1'b0}; // idle
    vecs[1]  = '{1'b1, 1'b0, NOARM, 10'd5, 1'b1, 10'd0, 1'b0}; // strobe, wrong st
    vecs[2]  = '{1'b0, 1'b1, ARM,   10'd0, 1'b0, 10'd0, 1'b0}; // wen ignored in idle
    vecs[3]  = '{1'b1, 1'b0, ARM,   10'd2, 1'b1, 10'd0, 1'b0}; // arm, len 2
    vecs[4]  = '{1'b0, 1'b1, ARM,   10'd0, 1'b1, 10'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, ARM,   10'd0, 1'b1, 10'd2, 1'b0}; // last byte
    vecs[6]  = '{1'b0, 1'b1, ARM,   10'd0, 1'b1, 10'd3, 1'b0}; // overrun byte
    vecs[7]  = '{1'b1, 1'b0, ARM,   10'd1, 1'b1, 10'd0, 1'b1}; // abort + re-arm
    vecs[8]  = '{1'b0, 1'b1, ARM,   10'd0, 1'b1, 10'd1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b100,10'd0, 1'b1, 10'd1, 1'b1}; // abort to idle
    vecs[10] = '{1'b0, 1'b0, ARM,   10'd0, 1'b0, 10'd1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].nr, vecs[i].w, vecs[i].s, vecs[i].len);
      check($sformatf("vec%0d_reply", i), 32'(bus.reply), 32'(vecs[i].e_reply));
      check($sformatf("vec%0d_cnt", i), 32'(bus.byte_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_abort", i), 32'(bus.err_abort), 32'(vecs[i].e_abort));
    end
    idle(3);

    // ---- clean 268-byte frame at 100-cycle spacing ----
    step(1'b1, 1'b0, ARM, 10'd268);
    all_high = 1;
    for (int b = 0; b < 268; b++) begin
      for (int j = 0; j < 99; j++) begin
        step(1'b0, 1'b0, ARM, '0);
        if (!bus.reply) all_high = 0;
      end
      step(1'b0, 1'b1, ARM, '0);
      if (!bus.reply) all_high = 0;
    end
    check("clean_reply_high", 32'(all_high), 32'd1);
    wait_pulse(3000, k, pd, po, pg);
    check("clean_done_latency", k, 2401);
    check("clean_done", 32'(pd), 32'd1);
    check("clean_ok", 32'(po), 32'd1);
    check("clean_cnt", 32'(bus.byte_cnt), 32'd268);
    check("clean_reply_low", 32'(bus.reply), 32'd0);

    // ---- gap timeout ----
    step(1'b1, 1'b0, ARM, 10'd4);
    idle(10); step(1'b0, 1'b1, ARM, '0);
    idle(10); step(1'b0, 1'b1, ARM, '0);
    wait_pulse(13000, k, pd, po, pg);
    check("gap_latency", k, G + 1);
    check("gap_flag", 32'(pg), 32'd1);
    check("gap_no_done", 32'(pd), 32'd0);
    check("gap_cnt", 32'(bus.byte_cnt), 32'd2);
    wait_pulse(500, k, pd, po, pg);
    check("gap_quiet_after", k, -1);

    // ---- overrun ----
    step(1'b1, 1'b0, ARM, 10'd3);
    for (int b = 0; b < 3; b++) begin idle(4); step(1'b0, 1'b1, ARM, '0); end
    idle(499); step(1'b0, 1'b1, ARM, '0);
    wait_pulse(3000, k, pd, po, pg);
    check("ovr_latency", k, 2401);
    check("ovr_done", 32'(pd), 32'd1);
    check("ovr_ok", 32'(po), 32'd0);
    check("ovr_cnt", 32'(bus.byte_cnt), 32'd4);

    // ---- abort and re-arm ----
    step(1'b1, 1'b0, ARM, 10'd5);
    idle(3); step(1'b0, 1'b1, ARM, '0);
    idle(3); step(1'b0, 1'b1, ARM, '0);
    step(1'b1, 1'b0, ARM, 10'd2);
    check("rearm_abort", 32'(bus.err_abort), 32'd1);
    check("rearm_cnt_clr", 32'(bus.byte_cnt), 32'd0);
    idle(3); step(1'b0, 1'b1, ARM, '0);
    idle(3); step(1'b0, 1'b1, ARM, '0);
    wait_pulse(3000, k, pd, po, pg);
    check("rearm_latency", k, 2401);
    check("rearm_done_ok", 32'({pd, po}), 32'b11);

    step(1'b1, 1'b0, ARM, 10'd5);
    idle(3); step(1'b0, 1'b1, ARM, '0);
    step(1'b1, 1'b0, NOARM, 10'd2);
    check("abort_idle_pulse", 32'(bus.err_abort), 32'd1);
    idle(1);
    check("abort_idle_reply", 32'(bus.reply), 32'd0);
    wait_pulse(500, k, pd, po, pg);
    check("abort_idle_nothing", k, -1);

    // ---- zero-length frame ----
    step(1'b1, 1'b0, ARM, 10'd0);
    wait_pulse(3000, k, pd, po, pg);
    check("zero_latency", k, 2401);
    check("zero_done_ok", 32'({pd, po}), 32'b11);

    // ---- wen on the exact gap-expiry cycle ----
    step(1'b1, 1'b0, ARM, 10'd2);
    idle(G);
    step(1'b0, 1'b1, ARM, '0);
    check("edge_wen_no_gap", 32'(bus.err_gap), 32'd0);
    check("edge_wen_cnt", 32'(bus.byte_cnt), 32'd1);
    step(1'b0, 1'b1, ARM, '0);
    wait_pulse(3000, k, pd, po, pg);
    check("edge_wen_done_latency", k, 2401);
    check("edge_wen_done_ok", 32'({pd, po, pg}), 32'b110);

    // ---- byte counter saturation in QUIET ----
    step(1'b1, 1'b0, ARM, 10'd1);
    step(1'b0, 1'b1, ARM, '0);
    for (int b = 0; b < 1030; b++) step(1'b0, 1'b1, ARM, '0);
    check("sat_cnt", 32'(bus.byte_cnt), 32'd1023);
    wait_pulse(3000, k, pd, po, pg);
    check("sat_done_ok", 32'({pd, po}), 32'b10);

    // ---- reset mid-QUIET ----
    step(1'b1, 1'b0, ARM, 10'd1);
    step(1'b0, 1'b1, ARM, '0);
    idle(100);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_quiet", dut_bundle(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_pulse(2600, k, pd, po, pg);
    check("rst_no_done", k, -1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) == 0) ? NOARM : ARM,
           10'($urandom_range(0, 6)));
    end
    idle(2500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
